// File: rtl/mux_rr_sel.sv
// mux_rr_sel
// ----------
// Registered N:1 multiplexer of WIDTH-bit channels with valid/ready handshakes
// on every input and on the output. The channel is chosen either by an
// explicit select (fixed mode) or by a round-robin arbiter over the valid
// channels (RR mode). One register stage decouples producers from the consumer.
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous, active-high reset
//   mode       0 = fixed select, 1 = round-robin
//   sel        channel index used in fixed mode
//   in_data    N packed channels, channel i at [i*WIDTH +: WIDTH]
//   in_valid   per-channel valid
//   in_ready   per-channel ready (combinational, at most one bit set)
//   out_data   registered selected data
//   out_chan   registered index of the channel that supplied out_data
//   out_valid  registered output valid
//   out_ready  consumer ready
module mux_rr_sel #(
    parameter int WIDTH = 64,
    parameter int N     = 8,
    parameter int SEL_W = $clog2(N)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 mode,
    input  logic [SEL_W-1:0]     sel,
    input  logic [N*WIDTH-1:0]   in_data,
    input  logic [N-1:0]         in_valid,
    output logic [N-1:0]         in_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic [SEL_W-1:0]     out_chan,
    output logic                 out_valid,
    input  logic                 out_ready
);

    // One extra bit so that ptr + offset (at most 2N-2) never overflows.
    localparam logic [SEL_W:0]   N_EXT = (SEL_W+1)'(N);
    localparam logic [SEL_W-1:0] LAST  = SEL_W'(N-1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] out_data_q,  out_data_d;
    logic [SEL_W-1:0] out_chan_q,  out_chan_d;
    logic             out_valid_q, out_valid_d;
    logic [SEL_W-1:0] ptr_q,       ptr_d;

    // ------------------------------------------------------------------
    // Round-robin scan: offset k looks at channel (ptr + k) mod N. The
    // modulo is a single conditional subtract because ptr < N always,
    // so non-power-of-two N never produces an index >= N.
    // ------------------------------------------------------------------
    logic [SEL_W-1:0] scan_idx [N];
    logic [N-1:0]     scan_hit;

    for (genvar gi = 0; gi < N; gi++) begin : g_scan
        logic [SEL_W:0] sum;
        assign sum          = {1'b0, ptr_q} + (SEL_W+1)'(gi);
        assign scan_idx[gi] = (sum >= N_EXT) ? SEL_W'(sum - N_EXT) : SEL_W'(sum);
        assign scan_hit[gi] = in_valid[scan_idx[gi]];
    end

    logic             rr_found;
    logic [SEL_W-1:0] rr_chan;

    // Lowest offset wins, i.e. the first valid channel at or after ptr.
    always_comb begin
        rr_found = 1'b0;
        rr_chan  = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (scan_hit[k]) begin
                rr_found = 1'b1;
                rr_chan  = scan_idx[k];
            end
        end
    end

    // ------------------------------------------------------------------
    // Candidate selection and handshake
    // ------------------------------------------------------------------
    logic             cand_ok;
    logic [SEL_W-1:0] cand;
    logic             load;
    logic             rdy_en;
    logic             grant;
    logic [WIDTH-1:0] grant_data;

    always_comb begin
        if (mode) begin
            cand_ok = rr_found;
            cand    = rr_chan;
        end else begin
            // Fixed mode ignores in_valid; an out-of-range select has no candidate.
            cand_ok = ({1'b0, sel} < N_EXT);
            cand    = sel;
        end
    end

    assign load   = !out_valid_q || out_ready;
    assign rdy_en = load && !reset && cand_ok;

    for (genvar gi = 0; gi < N; gi++) begin : g_ready
        assign in_ready[gi] = rdy_en && (cand == SEL_W'(gi));
    end

    assign grant = |(in_ready & in_valid);

    // in_ready is one-hot (or zero), so an AND-OR tree is a clean select
    // that never indexes past the last channel.
    always_comb begin
        grant_data = '0;
        for (int i = 0; i < N; i++) begin
            if (in_ready[i]) begin
                grant_data = grant_data | in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // ------------------------------------------------------------------
    // Next state
    // ------------------------------------------------------------------
    always_comb begin
        out_data_d  = out_data_q;
        out_chan_d  = out_chan_q;
        out_valid_d = out_valid_q;
        ptr_d       = ptr_q;
        if (load) begin
            if (grant) begin
                out_data_d  = grant_data;
                out_chan_d  = cand;
                out_valid_d = 1'b1;
                // ptr is frozen in fixed mode and only moves on RR grants.
                if (mode) begin
                    ptr_d = (cand == LAST) ? '0 : cand + 1'b1;
                end
            end else begin
                out_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_data_q  <= '0;
            out_chan_q  <= '0;
            out_valid_q <= 1'b0;
            ptr_q       <= '0;
        end else begin
            out_data_q  <= out_data_d;
            out_chan_q  <= out_chan_d;
            out_valid_q <= out_valid_d;
            ptr_q       <= ptr_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_chan  = out_chan_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_mux_rr_sel.sv
// Testbench for mux_rr_sel (N=6 build: non-power-of-two, sel values 6/7 out of range).
// Stimulus is driven every cycle; a reference model predicts in_ready and pushes
// each granted word onto a scoreboard queue. An independent monitor compares the
// registered output against the queue head and pops it on each accepted handshake.
module tb_mux_rr_sel;
    localparam int N     = 6;
    localparam int WIDTH = 64;
    localparam int SEL_W = $clog2(N);

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic [SEL_W-1:0] chan;
    } item_t;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               mode = 1'b1;
    logic [SEL_W-1:0]   sel = '0;
    logic [N*WIDTH-1:0] in_data = '0;
    logic [N-1:0]       in_valid = '1;
    logic [N-1:0]       in_ready;
    logic [WIDTH-1:0]   out_data;
    logic [SEL_W-1:0]   out_chan;
    logic               out_valid;
    logic               out_ready = 1'b1;

    always #5 clk = ~clk;

    mux_rr_sel #(.WIDTH(WIDTH), .N(N)) dut (
        .clk       (clk),
        .reset     (reset),
        .mode      (mode),
        .sel       (sel),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_chan  (out_chan),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    item_t sb_q[$];
    int    total = 0;
    int    bad   = 0;
    int    model_ptr = 0;
    bit    fixed_data = 1'b1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock cycle of stimulus plus reference-model prediction.
    task automatic cycle(input logic m, input logic [SEL_W-1:0] s, input logic [N-1:0] v,
                         input logic r, input logic rst);
        logic [WIDTH-1:0] d [N];
        logic [N-1:0]     exp_rdy;
        bit               has;
        bit               load;
        int               c;
        int               idx;
        item_t            it;
        @(negedge clk);
        #2;
        mode      = m;
        sel       = s;
        in_valid  = v;
        out_ready = r;
        reset     = rst;
        for (int i = 0; i < N; i++) begin
            d[i] = fixed_data ? {32'hDEAD_BEEF, 32'(i)} : {$urandom, $urandom};
            in_data[i*WIDTH +: WIDTH] = d[i];
        end
        #1;
        exp_rdy = '0;
        has     = 1'b0;
        c       = 0;
        if (rst) begin
            sb_q.delete();
            model_ptr = 0;
        end else begin
            // Output register is full exactly when the scoreboard holds a word.
            load = (sb_q.size() == 0) || r;
            if (!m) begin
                if (int'(s) < N) begin
                    has = 1'b1;
                    c   = int'(s);
                end
            end else begin
                for (int k = 0; k < N; k++) begin
                    idx = (model_ptr + k) % N;
                    if (!has && v[idx]) begin
                        has = 1'b1;
                        c   = idx;
                    end
                end
            end
            if (load && has) exp_rdy[c] = 1'b1;
        end
        check("in_ready", 64'(in_ready), 64'(exp_rdy));
        if (exp_rdy != '0 && v[c]) begin
            it.data = d[c];
            it.chan = SEL_W'(c);
            sb_q.push_back(it);
            if (m) model_ptr = (c + 1) % N;
            $display("grant chan=%0d mode=%0d data=%h", c, m, d[c]);
        end
    endtask

    // Monitor: compare at negedge+1, pop accepted word at negedge+4 (before the edge).
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (reset) begin
                check("rst_out_valid", 64'(out_valid), 64'(0));
                check("rst_out_data", 64'(out_data), 64'(0));
                check("rst_out_chan", 64'(out_chan), 64'(0));
            end else begin
                check("out_valid", 64'(out_valid), 64'(sb_q.size() > 0));
                if (out_valid && sb_q.size() > 0) begin
                    check("out_data", 64'(out_data), 64'(sb_q[0].data));
                    check("out_chan", 64'(out_chan), 64'(sb_q[0].chan));
                end
            end
            #3;
            if (!reset && out_valid && out_ready && sb_q.size() > 0) begin
                $display("accept chan=%0d data=%h", out_chan, out_data);
                void'(sb_q.pop_front());
            end
        end
    end

    initial begin
        // Reset for two cycles with every channel valid.
        cycle(1'b1, 3'd0, '1, 1'b1, 1'b1);
        cycle(1'b1, 3'd0, '1, 1'b1, 1'b1);
        // RR fairness: two full rounds, first grant to channel 0.
        for (int i = 0; i < 2 * N; i++) cycle(1'b1, 3'd0, '1, 1'b1, 1'b0);
        // Fixed select of channel 5, then drain.
        cycle(1'b0, 3'd5, 6'b100000, 1'b1, 1'b0);
        cycle(1'b0, 3'd5, 6'b000000, 1'b1, 1'b0);
        // Skip and wrap: move ptr to 4, then channels 0 and 2 only.
        cycle(1'b1, 3'd0, 6'b001000, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b1, 3'd0, 6'b000101, 1'b1, 1'b0);
        // ptr = N-1 with only channel 0 valid.
        cycle(1'b1, 3'd0, 6'b010000, 1'b1, 1'b0);
        cycle(1'b1, 3'd0, 6'b000001, 1'b1, 1'b0);
        // Back-pressure for 3 cycles, then release.
        for (int i = 0; i < 3; i++) cycle(1'b1, 3'd0, '1, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) cycle(1'b1, 3'd0, '1, 1'b1, 1'b0);
        // Out-of-range fixed select: no candidate, output drains.
        for (int i = 0; i < 3; i++) cycle(1'b0, 3'd7, '1, 1'b1, 1'b0);
        // Mode toggling while a word is held, then RR resumes.
        cycle(1'b1, 3'd0, '1, 1'b1, 1'b0);
        cycle(1'b0, 3'd2, '1, 1'b0, 1'b0);
        cycle(1'b1, 3'd2, '1, 1'b0, 1'b0);
        cycle(1'b0, 3'd2, '1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b1, 3'd0, '1, 1'b1, 1'b0);
        // Randomized traffic with occasional reset.
        fixed_data = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            cycle(1'($urandom_range(0, 1)), SEL_W'($urandom_range(0, 7)), N'($urandom),
                  ($urandom_range(0, 3) != 0), ($urandom_range(0, 99) == 0));
        end
        // Drain.
        for (int i = 0; i < 3; i++) cycle(1'b1, 3'd0, '0, 1'b1, 1'b0);
        @(negedge clk);
        #2;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
